a_st_serializer_arb: RTL and testbench
======================================

// Module: a_st_serializer_arb
// PURPOSE
//  Shares one narrow 11-bit (aBiggerT) beat link between NUM_REQ producers of aSt records.
//  Round-robin arbiter grants one requester at a time and captures its aSt into a holding register.
//  A sequencer then streams the record as 13 beats with valid/ready backpressure.
//  Sits between the hierInclude record producers and the shared downstream transport.
// PARAMETERS
//  NUM_REQ   2        number of requesters (1..8)
//  ELEM_CNT  ASIZE2   variablea2 elements per record (11); total beats = ELEM_CNT+2
// PORTS
//  clk         in   1                  single clock, all logic rising-edge
//  rst         in   1                  asynchronous, active-high reset
//  req_valid   in   NUM_REQ            per-requester record valid
//  req_data    in   NUM_REQ x aSt      per-requester record (hierInclude_package::aSt)
//  req_ready   out  NUM_REQ            one-hot accept; at most one bit high
//  out_valid   out  1                  beat valid
//  out_ready   in   1                  downstream accepts beat when out_valid&&out_ready
//  out_data    out  11                 beat payload (aBiggerT)
//  out_first   out  1                  high on beat 0
//  out_last    out  1                  high on final beat (index ELEM_CNT+1)
//  out_src     out  $clog2(NUM_REQ)    index of requester owning current record (width min 1)
// BEHAVIOUR
//  - Reset: state IDLE, rr_ptr=0, beat_idx=0, out_valid=0, req_ready=0, out_first/out_last=0,
//    out_data=0, out_src=0, holding register cleared. Applies immediately (async).
//  - States: IDLE -> SEND on accept; SEND -> IDLE on handshake of last beat. No other states.
//  - IDLE: req_ready = one-hot of first set req_valid searching from rr_ptr upward, wrapping.
//    req_ready is combinational from req_valid/rr_ptr; low in SEND regardless of req_valid.
//  - Accept (req_valid[g]&&req_ready[g]): latch req_data[g] and g; rr_ptr <= (g+1) mod NUM_REQ;
//    beat_idx<=0; state<=SEND. out_valid rises the cycle after accept (1-cycle latency).
//  - Requesters hold req_valid and req_data stable until accepted; dropping early is legal
//    and simply removes that requester from the next arbitration.
//  - Beat map: 0 = {another, variablea} (4+7); 1 = {3'b0, yetAnother};
//    2+i = variablea2[i], i=0..ELEM_CNT-1 (index 0 first).
//  - SEND: out_valid=1; out_data/out_first/out_last/out_src registered, stable while
//    out_valid&&!out_ready. beat_idx increments only on handshake; no skip, no repeat.
//  - Last-beat handshake: out_valid drops next cycle, state IDLE; next accept earliest the
//    cycle after that (1 bubble between records, no back-to-back overlap).
//  - Reset mid-record: record discarded, no further beats; rr_ptr returns to 0.
//  - rr_ptr wrap: NUM_REQ-1 grant sets rr_ptr=0. NUM_REQ=1: fixed grant, rr_ptr stays 0.
//  - Simultaneous valids: only rr-winner accepted; others wait, no starvation (max NUM_REQ-1 records).
// CONFIGURATION
//  A_ST_SER_PARITY_EN defined: extra output out_parity (1) = ^out_data, registered with beat,
//    stable under backpressure, reset 0.
//  Not defined: port absent, no parity logic; all other behaviour identical.
// TESTING
//  1 req0 only, variablea=7'h55, another=4'hA, yetAnother=8'hC3, variablea2[i]=i+1, out_ready=1
//    -> 13 beats 11'h555, 11'h0C3, 1..11; out_first beat0, out_last beat12, out_src=0, first valid accept+1.
//  2 req0,req1 held valid from reset, two records each -> grant order 0,1,0,1; one bubble between records.
//  3 out_ready low 3 cycles at beat 5 -> out_data=11'h004 held 3 cycles, then beats 6..12 in order.
//  4 rst pulsed during beat 7 -> out_valid=0 immediately; after release req0 (still valid)
//    re-accepted, full 13-beat record from beat 0.
//  5 NUM_REQ=3, req1,req2 valid -> grant 1 then 2, rr_ptr wraps to 0; req0 raised then wins next.
//  6 A_ST_SER_PARITY_EN, variablea2[0]=11'h001, variablea2[1]=11'h003 -> out_parity 1 on beat 2,
//    0 on beat 3; 0 on beats 0,1 of test-1 record.

Source files
------------

// File: rtl/a_st_serializer_arb_if.sv
// Record types shared with the hierInclude producers, plus the arbiter/serializer bus interface.
// out_parity exists only when A_ST_SER_PARITY_EN is defined.
package hierInclude_package;
    localparam int ASIZE2 = 11;

    typedef logic [10:0] aBiggerT;

    typedef struct packed {
        logic [3:0]               another;
        logic [6:0]               variablea;
        logic [7:0]               yetAnother;
        aBiggerT [ASIZE2-1:0]     variablea2;
    } aSt;
endpackage

interface a_st_serializer_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();
    logic [NUM_REQ-1:0]                        req_valid;
    hierInclude_package::aSt [NUM_REQ-1:0]     req_data;
    logic [NUM_REQ-1:0]                        req_ready;
    logic                                      out_valid;
    logic                                      out_ready;
    hierInclude_package::aBiggerT              out_data;
    logic                                      out_first;
    logic                                      out_last;
    logic [SRC_W-1:0]                          out_src;
`ifdef A_ST_SER_PARITY_EN
    logic                                      out_parity;
`endif

    modport master (
`ifdef A_ST_SER_PARITY_EN
        input  out_parity,
`endif
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_first, out_last, out_src
    );

    modport slave (
`ifdef A_ST_SER_PARITY_EN
        output out_parity,
`endif
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_first, out_last, out_src
    );
endinterface

// File: rtl/a_st_serializer_arb.sv
// Round-robin arbiter that captures one aSt record and streams it as ELEM_CNT+2 11-bit beats.
// Define A_ST_SER_PARITY_EN to add the registered out_parity output.
module a_st_serializer_arb
    import hierInclude_package::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ELEM_CNT = ASIZE2
) (
    input  logic                 clk,
    input  logic                 rst,
    a_st_serializer_arb_if.slave bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEATS = ELEM_CNT + 2;
    localparam int BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

    typedef enum logic {IDLE, SEND} stateT;

    stateT              r_state;
    stateT              w_nextState;
    aSt                 r_hold;
    logic [SRC_W-1:0]   r_src;
    logic [SRC_W-1:0]   r_rrPtr;
    logic [BW-1:0]      r_beatIdx;
    aBiggerT            r_outData;
    logic               r_outFirst;
    logic               r_outLast;
`ifdef A_ST_SER_PARITY_EN
    logic               r_outParity;
`endif

    logic [NUM_REQ-1:0] w_grant;
    logic [SRC_W-1:0]   w_grantIdx;
    logic [SRC_W-1:0]   w_nextPtr;
    logic               w_found;
    logic               w_beatHs;
    logic               w_lastHs;
    aSt                 w_pickRec;
    aBiggerT            w_loadBeat;

    function automatic aBiggerT beatOf(input aSt rec, input logic [BW-1:0] idx);
        aBiggerT beat;
        beat = {rec.another, rec.variablea};
        if (idx == BW'(1)) beat = {3'b000, rec.yetAnother};
        for (int i = 0; i < ELEM_CNT; i++) begin
            if (idx == BW'(i + 2)) beat = rec.variablea2[i];
        end
        return beat;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // Two-pass search: rr_ptr..NUM_REQ-1 first, then wrap to 0.
    always_comb begin
        w_grant     = '0;
        w_grantIdx  = '0;
        w_found     = 1'b0;
        w_pickRec   = '0;
        w_nextState = r_state;
        if (r_state == IDLE && !rst) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && j >= int'(r_rrPtr) && bus.req_valid[j]) begin
                    w_found    = 1'b1;
                    w_grant[j] = 1'b1;
                    w_grantIdx = SRC_W'(j);
                    w_pickRec  = bus.req_data[j];
                end
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && bus.req_valid[j]) begin
                    w_found    = 1'b1;
                    w_grant[j] = 1'b1;
                    w_grantIdx = SRC_W'(j);
                    w_pickRec  = bus.req_data[j];
                end
            end
        end
        w_beatHs = (r_state == SEND) && bus.out_ready;
        w_lastHs = w_beatHs && (r_beatIdx == LAST_IDX);
        case (r_state)
            IDLE:    if (w_found)  w_nextState = SEND;
            SEND:    if (w_lastHs) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        w_nextPtr  = (int'(w_grantIdx) == NUM_REQ - 1) ? '0 : w_grantIdx + SRC_W'(1);
        w_loadBeat = w_found ? beatOf(w_pickRec, '0) : beatOf(r_hold, r_beatIdx + BW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_src       <= '0;
            r_rrPtr     <= '0;
            r_beatIdx   <= '0;
            r_outData   <= '0;
            r_outFirst  <= 1'b0;
            r_outLast   <= 1'b0;
`ifdef A_ST_SER_PARITY_EN
            r_outParity <= 1'b0;
`endif
        end else if (w_found) begin
            r_hold      <= w_pickRec;
            r_src       <= w_grantIdx;
            r_rrPtr     <= w_nextPtr;
            r_beatIdx   <= '0;
            r_outData   <= w_loadBeat;
            r_outFirst  <= 1'b1;
            r_outLast   <= 1'b0;
`ifdef A_ST_SER_PARITY_EN
            r_outParity <= ^w_loadBeat;
`endif
        end else if (w_lastHs) begin
            r_beatIdx   <= '0;
            r_outFirst  <= 1'b0;
            r_outLast   <= 1'b0;
        end else if (w_beatHs) begin
            r_beatIdx   <= r_beatIdx + BW'(1);
            r_outData   <= w_loadBeat;
            r_outFirst  <= 1'b0;
            r_outLast   <= (r_beatIdx + BW'(1)) == LAST_IDX;
`ifdef A_ST_SER_PARITY_EN
            r_outParity <= ^w_loadBeat;
`endif
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.out_valid  = (r_state == SEND);
    assign bus.out_data   = r_outData;
    assign bus.out_first  = r_outFirst;
    assign bus.out_last   = r_outLast;
    assign bus.out_src    = r_src;
`ifdef A_ST_SER_PARITY_EN
    assign bus.out_parity = r_outParity;
`endif
endmodule

// File: tb/tb_a_st_serializer_arb.sv
// Self-checking bench for a_st_serializer_arb: directed scenarios plus a randomized phase,
// all compared every cycle against a queue-based record/beat model.
module tb_a_st_serializer_arb;
    import hierInclude_package::*;

    localparam int N     = 3;
    localparam int BEATS = ASIZE2 + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    a_st_serializer_arb_if #(.NUM_REQ(N)) bus ();

    a_st_serializer_arb #(.NUM_REQ(N), .ELEM_CNT(ASIZE2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a busy flag, a queue of beats still owed, and the round-robin pointer.
    bit            mBusy;
    int            mRr;
    int            mBeatNo;
    int            mSrc;
    logic [10:0]   expQ[$];

    logic [N-1:0]  drvValid;
    aSt            drvData[N];
    int            remaining[N];
    bit            reload[N];
    bit            fixedData[N];

    int            readyPct;
    int            stallAtBeat;
    int            stallLen;
    int            stallDone;
    int            stallHeld;

    int            obsGrants[$];
    logic [10:0]   obsBeats[$];
    logic          obsParity[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic void expBeats(input aSt r);
        expQ.delete();
        expQ.push_back({r.another, r.variablea});
        expQ.push_back({3'b000, r.yetAnother});
        for (int i = 0; i < ASIZE2; i++) expQ.push_back(r.variablea2[i]);
    endfunction

    function automatic aSt randomRec();
        aSt r;
        r.another    = 4'($urandom);
        r.variablea  = 7'($urandom);
        r.yetAnother = 8'($urandom);
        for (int i = 0; i < ASIZE2; i++) r.variablea2[i] = 11'($urandom);
        return r;
    endfunction

    function automatic aSt countRec();
        aSt r;
        r.another    = 4'hA;
        r.variablea  = 7'h55;
        r.yetAnother = 8'hC3;
        for (int i = 0; i < ASIZE2; i++) r.variablea2[i] = 11'(i + 1);
        return r;
    endfunction

    task automatic driveBus();
        bus.req_valid = drvValid;
        for (int g = 0; g < N; g++) bus.req_data[g] = drvData[g];
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            if (reload[g]) begin
                reload[g] = 1'b0;
                if (remaining[g] > 0) begin
                    drvValid[g] = 1'b1;
                    if (!fixedData[g]) drvData[g] = randomRec();
                end else begin
                    drvValid[g] = 1'b0;
                end
            end
        end
        if (mBusy && mBeatNo == stallAtBeat && stallDone < stallLen) begin
            bus.out_ready = 1'b0;
            stallDone++;
        end else begin
            bus.out_ready = ($urandom_range(99) < readyPct);
        end
        driveBus();
        #1;
    endtask

    task automatic modelStep();
        int          win;
        logic [N-1:0] expReady;
        checkOutput("out_valid", bus.out_valid, mBusy);
        win = -1;
        if (!mBusy) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mRr + k) % N;
                if (win < 0 && drvValid[c]) win = c;
            end
        end
        expReady = '0;
        if (win >= 0) expReady[win] = 1'b1;
        checkOutput("req_ready", bus.req_ready, expReady);
        for (int g = 0; g < N; g++) if (bus.req_ready[g] === 1'b1) obsGrants.push_back(g);
        if (mBusy) begin
            checkOutput("out_data", bus.out_data, expQ[0]);
            checkOutput("out_first", bus.out_first, mBeatNo == 0);
            checkOutput("out_last", bus.out_last, expQ.size() == 1);
            checkOutput("out_src", bus.out_src, mSrc);
`ifdef A_ST_SER_PARITY_EN
            checkOutput("out_parity", bus.out_parity, ^expQ[0]);
`endif
            if (!bus.out_ready && bus.out_data === 11'h004) stallHeld++;
            if (bus.out_ready) begin
                obsBeats.push_back(bus.out_data);
`ifdef A_ST_SER_PARITY_EN
                obsParity.push_back(bus.out_parity);
`endif
                void'(expQ.pop_front());
                mBeatNo++;
                if (expQ.size() == 0) mBusy = 1'b0;
            end
        end else if (win >= 0) begin
            mBusy   = 1'b1;
            mBeatNo = 0;
            mSrc    = win;
            expBeats(drvData[win]);
            mRr     = (win + 1) % N;
            remaining[win]--;
            reload[win] = 1'b1;
        end
    endtask

    task automatic cycle();
        applyStimulus();
        modelStep();
    endtask

    task automatic checkResetState();
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_req_ready", bus.req_ready, '0);
        checkOutput("rst_out_data", bus.out_data, 11'h000);
        checkOutput("rst_out_first", bus.out_first, 1'b0);
        checkOutput("rst_out_last", bus.out_last, 1'b0);
        checkOutput("rst_out_src", bus.out_src, 0);
`ifdef A_ST_SER_PARITY_EN
        checkOutput("rst_out_parity", bus.out_parity, 1'b0);
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetState();
        mBusy = 1'b0;
        expQ.delete();
        mRr = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        modelStep();
    endtask

    task automatic runUntilIdle(input int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((mBusy || drvValid != '0) && n < budget);
        checkOutput("drain", (mBusy || drvValid != '0) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic runUntilBeat(input int beat, input int budget);
        int n;
        n = 0;
        while (!(mBusy && mBeatNo == beat) && n < budget) begin
            cycle();
            n++;
        end
        checkOutput("reach_beat", (mBusy && mBeatNo == beat) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic runUntilGrants(input int cnt, input int budget);
        int n;
        n = 0;
        while (obsGrants.size() < cnt && n < budget) begin
            cycle();
            n++;
        end
        checkOutput("reach_grants", obsGrants.size() >= cnt ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        aSt rec;
        int total;

        rst = 1'b1;
        bus.out_ready = 1'b0;
        drvValid = '0;
        for (int g = 0; g < N; g++) begin
            drvData[g]   = '0;
            remaining[g] = 0;
            reload[g]    = 1'b0;
            fixedData[g] = 1'b0;
        end
        driveBus();
        mBusy = 1'b0; mRr = 0; mBeatNo = 0; mSrc = 0;
        readyPct = 100; stallAtBeat = -1; stallLen = 0; stallDone = 0; stallHeld = 0;
        #1;
        checkResetState();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        modelStep();

        $display("[TB] test 1: single record, out_ready always high");
        fixedData[0] = 1'b1; drvData[0] = countRec(); remaining[0] = 1; reload[0] = 1'b1;
        obsBeats.delete(); obsParity.delete();
        runUntilIdle(60);
        checkOutput("t1_beat_count", obsBeats.size(), BEATS);
        checkOutput("t1_beat0", obsBeats[0], 11'h555);
        checkOutput("t1_beat1", obsBeats[1], 11'h0C3);
        checkOutput("t1_beat12", obsBeats[12], 11'd11);
`ifdef A_ST_SER_PARITY_EN
        checkOutput("t1_par0", obsParity[0], 1'b0);
        checkOutput("t1_par1", obsParity[1], 1'b0);
`endif

        $display("[TB] test 3/6: stall at beat 5, parity data");
        rec = countRec(); rec.variablea2[1] = 11'h003;
        drvData[0] = rec; remaining[0] = 1; reload[0] = 1'b1;
        stallAtBeat = 5; stallLen = 3; stallDone = 0; stallHeld = 0;
        obsBeats.delete(); obsParity.delete();
        runUntilIdle(60);
        stallAtBeat = -1;
        checkOutput("t3_stall_held", stallHeld, 3);
        checkOutput("t3_beat_count", obsBeats.size(), BEATS);
        checkOutput("t3_beat5", obsBeats[5], 11'h004);
        checkOutput("t3_beat6", obsBeats[6], 11'h005);
`ifdef A_ST_SER_PARITY_EN
        checkOutput("t6_par2", obsParity[2], 1'b1);
        checkOutput("t6_par3", obsParity[3], 1'b0);
`endif
        fixedData[0] = 1'b0;

        $display("[TB] test 2: two requesters, two records each");
        doReset();
        obsGrants.delete();
        remaining[0] = 2; reload[0] = 1'b1;
        remaining[1] = 2; reload[1] = 1'b1;
        runUntilIdle(200);
        checkOutput("t2_grant_count", obsGrants.size(), 4);
        checkOutput("t2_grant0", obsGrants[0], 0);
        checkOutput("t2_grant1", obsGrants[1], 1);
        checkOutput("t2_grant2", obsGrants[2], 0);
        checkOutput("t2_grant3", obsGrants[3], 1);

        $display("[TB] test 4: reset during beat 7");
        remaining[0] = 3; reload[0] = 1'b1;
        runUntilBeat(7, 60);
        doReset();
        obsGrants.delete(); obsBeats.delete();
        runUntilIdle(200);
        checkOutput("t4_first_grant", obsGrants[0], 0);
        checkOutput("t4_beat_count", obsBeats.size(), 2 * BEATS);

        $display("[TB] test 5: three-way wrap");
        doReset();
        obsGrants.delete();
        remaining[1] = 2; reload[1] = 1'b1;
        remaining[2] = 1; reload[2] = 1'b1;
        runUntilGrants(2, 100);
        remaining[0] = 1; reload[0] = 1'b1;
        runUntilIdle(200);
        checkOutput("t5_grant_count", obsGrants.size(), 4);
        checkOutput("t5_grant0", obsGrants[0], 1);
        checkOutput("t5_grant1", obsGrants[1], 2);
        checkOutput("t5_grant2", obsGrants[2], 0);
        checkOutput("t5_grant3", obsGrants[3], 1);

        $display("[TB] random phase");
        doReset();
        obsGrants.delete();
        readyPct = 60;
        total = 0;
        for (int g = 0; g < N; g++) begin
            remaining[g] = $urandom_range(3, 1);
            total += remaining[g];
            reload[g] = 1'b1;
        end
        runUntilIdle(2000);
        checkOutput("rand_grant_count", obsGrants.size(), total);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
